mac_pipe: RTL

//   Parametrised, pipelined multiply-add/accumulate unit; successor to the fixed 8x8+16 multiply-add core.

---
 rtl/mac_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined multiply-add / accumulate unit with valid/ready handshakes.
// S1 registers the operands, S2 registers the product, S3 combines it and registers o/ovf.
// Build option MAC_SAT_EN: results outside the O_W range clamp to max/min and raise ovf.
// Without it, results wrap modulo 2^O_W and ovf is tied low.
module mac_pipe #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int C_W    = 16,
  parameter int O_W    = 16,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] ci,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [O_W-1:0] o,
  output logic           ovf
);

  localparam int P_W  = A_W + B_W;
  localparam int M1_W = (P_W > C_W) ? P_W : C_W;
  localparam int M2_W = (M1_W > O_W) ? M1_W : O_W;
  // Two guard bits: one for the carry of an add, one so a subtraction result stays signed.
  localparam int R_W  = M2_W + 2;
  localparam bit SGN  = (SIGNED != 0);

  localparam logic [1:0] MODE_MADD  = 2'b00;
  localparam logic [1:0] MODE_MACC  = 2'b01;
  localparam logic [1:0] MODE_MLOAD = 2'b10;
  localparam logic [1:0] MODE_MSUB  = 2'b11;

  logic           adv;
  logic           s1_valid;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic [C_W-1:0] s1_ci;
  logic [1:0]     s1_mode;
  logic           s2_valid;
  logic [P_W-1:0] s2_p;
  logic [C_W-1:0] s2_ci;
  logic [1:0]     s2_mode;
  logic [O_W-1:0] acc;

  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;
  logic [P_W-1:0] p_next;
  logic [R_W-1:0] p_r;
  logic [R_W-1:0] ci_r;
  logic [R_W-1:0] acc_r;
  logic [R_W-1:0] r;
  logic [O_W-1:0] o_next;
  logic           ovf_next;

  // One global stall: everything moves only when the output slot is free or being taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operands extended to the product width; the low P_W bits of this product are exact
  // for both unsigned and two's-complement operands.
  assign a_ext  = {{B_W{SGN & s1_a[A_W-1]}}, s1_a};
  assign b_ext  = {{A_W{SGN & s1_b[B_W-1]}}, s1_b};
  assign p_next = a_ext * b_ext;

  assign p_r   = {{(R_W-P_W){SGN & s2_p[P_W-1]}}, s2_p};
  assign ci_r  = {{(R_W-C_W){SGN & s2_ci[C_W-1]}}, s2_ci};
  assign acc_r = {{(R_W-O_W){SGN & acc[O_W-1]}}, acc};

  // Full-precision combine selected by the transaction's mode.
  always_comb begin
    r = '0;
    case (s2_mode)
      MODE_MADD:  r = p_r + ci_r;
      MODE_MACC:  r = acc_r + p_r;
      MODE_MLOAD: r = ci_r;
      MODE_MSUB:  r = ci_r - p_r;
      default:    r = '0;
    endcase
  end

`ifdef MAC_SAT_EN
  // Clamp out-of-range results; r's top bit is its sign thanks to the guard bits.
  always_comb begin
    o_next   = r[O_W-1:0];
    ovf_next = 1'b0;
    if (SGN) begin
      if (r[R_W-1:O_W-1] != {(R_W-O_W+1){r[R_W-1]}}) begin
        ovf_next = 1'b1;
        o_next   = r[R_W-1] ? {1'b1, {(O_W-1){1'b0}}} : {1'b0, {(O_W-1){1'b1}}};
      end
    end else if (r[R_W-1:O_W] != '0) begin
      ovf_next = 1'b1;
      o_next   = r[R_W-1] ? {O_W{1'b0}} : {O_W{1'b1}};
    end
  end
`else
  logic unused_r;
  assign o_next   = r[O_W-1:0];
  assign ovf_next = 1'b0;
  assign unused_r = ^r[R_W-1:O_W];
`endif

  // Stage valid bits shift together under the stall and are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  // Datapath stage registers; contents are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_ci   <= ci;
      s1_mode <= mode;
      s2_p    <= p_next;
      s2_ci   <= s1_ci;
      s2_mode <= s1_mode;
    end
  end

  // Output stage and accumulator; bubbles pass without disturbing o, ovf or acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        o   <= o_next;
        ovf <= ovf_next;
        if (s2_mode == MODE_MACC || s2_mode == MODE_MLOAD) begin
          acc <= o_next;
        end
      end
    end
  end

endmodule
